gray_counter: RTL and testbench

- Parametrised, registered Gray-code counter; the sequential successor to the team's combinational 4-bit binary-to-Gray converter.
- Holds a WIDTH-bit binary count and presents both binary and Gray forms from registers, so the Gray output is glitch-free for clock-domain-crossing pointers.
- Counts up or down, wraps, and can be loaded from either a binary or a Gray value.
- Used as the pointer generator for async FIFOs and position encoders elsewhere in the design.

---
 rtl/gray_counter_pkg.sv | 39 +++
 rtl/gray_counter_gray2bin_conv.sv | 30 +++
 rtl/gray_counter.sv | 108 ++++++++++
 tb/tb_gray_counter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/gray_counter_pkg.sv
// ---------------------------------------------------------------------------
// gray_pkg
//   Shared helpers for the Gray-code counter family.
//   - DEFAULT_WIDTH : default counter width.
//   - MAX_WIDTH     : widest vector the helper functions handle.
//   - action_t      : the three things a counter can do on an edge.
//   - bin2gray / gray2bin : width-generic conversions. Callers zero-extend
//     their WIDTH-bit value to wide_t and truncate the result back. Leading
//     zeros map to leading zeros in both directions, so the result is
//     correct for any WIDTH <= MAX_WIDTH.
// ---------------------------------------------------------------------------
package gray_pkg;

  localparam int DEFAULT_WIDTH = 4;
  localparam int MAX_WIDTH     = 64;

  typedef logic [MAX_WIDTH-1:0] wide_t;

  typedef enum logic [1:0] {
    ACT_HOLD = 2'd0,
    ACT_LOAD = 2'd1,
    ACT_STEP = 2'd2
  } action_t;

  function automatic wide_t bin2gray(input wide_t b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB down: b[i] = b[i+1] ^ g[i].
  function automatic wide_t gray2bin(input wide_t g);
    wide_t b;
    b[MAX_WIDTH-1] = g[MAX_WIDTH-1];
    for (int i = MAX_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_counter_gray2bin_conv.sv
// ---------------------------------------------------------------------------
// gray2bin_conv
//   Combinational Gray-to-binary converter (prefix XOR from the MSB down).
//   Ports:
//     gray : input  [WIDTH-1:0]  Gray-coded value
//     bin  : output [WIDTH-1:0]  equivalent binary value
// ---------------------------------------------------------------------------
module gray2bin_conv
  import gray_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  // A running parity bit carries the prefix XOR. The result vector is
  // never read back, which keeps the logic a clean feed-forward chain.
  logic acc;

  always_comb begin
    acc = 1'b0;
    bin = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      acc    = acc ^ gray[i];
      bin[i] = acc;
    end
  end

endmodule

// File: rtl/gray_counter.sv
// ---------------------------------------------------------------------------
// gray_counter
//   Registered up/down Gray-code counter. Binary and Gray forms both come
//   from flops, so the Gray output is glitch-free for use as a CDC pointer.
//   Priority on each rising edge: load > step (en) > hold.
//
//   Parameters:
//     WIDTH   : counter width in bits (>= 2)
//     RST_VAL : binary value loaded on reset
//
//   Ports:
//     clk          : input            system clock, rising edge
//     rst_n        : input            asynchronous active-low reset
//     en           : input            step enable, one step per cycle
//     up           : input            1 = increment, 0 = decrement
//     load         : input            synchronous load strobe
//     load_is_gray : input            1 = load_val is Gray-coded
//     load_val     : input  [WIDTH]   value to load
//     bin          : output [WIDTH]   registered binary count
//     gray         : output [WIDTH]   registered Gray count
//     tc           : output           combinational terminal count
//     wrap         : output           registered pulse after a wrapping step
//
//   Build option:
//     GRAY_CNT_SAT_EN : when defined, a step taken at terminal count is
//                       blocked (saturating counter), and wrap pulses to
//                       flag the blocked step instead of a rollover.
// ---------------------------------------------------------------------------
module gray_counter
  import gray_pkg::*;
#(
  parameter int               WIDTH   = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic             load_is_gray,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] RST_GRAY = RST_VAL ^ (RST_VAL >> 1);

  action_t          action;
  logic [WIDTH-1:0] load_bin;
  logic [WIDTH-1:0] stepped;
  logic [WIDTH-1:0] next_bin;
  logic [WIDTH-1:0] next_gray;
  logic             next_wrap;

  gray2bin_conv #(.WIDTH(WIDTH)) u_load_conv (
    .gray (load_val),
    .bin  (load_bin)
  );

  assign tc      = up ? (&bin) : ~(|bin);
  assign stepped = up ? (bin + WIDTH'(1)) : (bin - WIDTH'(1));

  always_comb begin
    action = ACT_HOLD;
    if (load) begin
      action = ACT_LOAD;
    end else if (en) begin
      action = ACT_STEP;
    end
  end

  // Gray is derived from next_bin, not from the current register, so both
  // registers always change on the same edge and gray never lags bin.
  always_comb begin
    next_bin  = bin;
    next_wrap = 1'b0;
    case (action)
      ACT_LOAD: next_bin = load_is_gray ? load_bin : load_val;
      ACT_STEP: begin
`ifdef GRAY_CNT_SAT_EN
        if (!tc) begin
          next_bin = stepped;
        end
`else
        next_bin = stepped;
`endif
        next_wrap = tc;
      end
      default: next_bin = bin;
    endcase
    next_gray = WIDTH'(bin2gray(wide_t'(next_bin)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin  <= RST_VAL;
      gray <= RST_GRAY;
      wrap <= 1'b0;
    end else begin
      bin  <= next_bin;
      gray <= next_gray;
      wrap <= next_wrap;
    end
  end

endmodule

// File: tb/tb_gray_counter.sv
// ---------------------------------------------------------------------------
// tb_gray_counter
//   Self-checking bench for gray_counter (WIDTH=4, RST_VAL=0). A counter
//   model kept as a plain integer is stepped with modular arithmetic and
//   compared against the DUT every cycle; directed steps pin the model with
//   hand-worked literals, then randomized traffic runs against the model.
// ---------------------------------------------------------------------------
module tb_gray_counter;

  localparam int         W       = 4;
  localparam int         MAXV    = (1 << W) - 1;
  localparam logic [W-1:0] RST_VAL = '0;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic         up;
  logic         load;
  logic         load_is_gray;
  logic [W-1:0] load_val;
  logic [W-1:0] bin;
  logic [W-1:0] gray;
  logic         tc;
  logic         wrap;

  int checks   = 0;
  int errors   = 0;
  bit check_en = 0;

  int   m_bin  = int'(RST_VAL);
  bit   m_wrap = 0;
  logic [W-1:0] last_gray;

  gray_counter #(.WIDTH(W), .RST_VAL(RST_VAL)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .up           (up),
    .load         (load),
    .load_is_gray (load_is_gray),
    .load_val     (load_val),
    .bin          (bin),
    .gray         (gray),
    .tc           (tc),
    .wrap         (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inverse Gray by search: the value whose Gray code equals g.
  function automatic int gray_inv(input int g);
    for (int v = 0; v <= MAXV; v++) begin
      if ((v ^ (v >> 1)) == g) return v;
    end
    return -1;
  endfunction

  function automatic bit model_tc(input int b, input bit dir_up);
    return dir_up ? (b == MAXV) : (b == 0);
  endfunction

  // Asynchronous reset in the model.
  always @(negedge rst_n) begin
    m_bin  = int'(RST_VAL);
    m_wrap = 0;
  end

  // Model update on each rising edge, then compare every output 1ns later.
  always begin
    bit hit;
    bit step_taken;
    int exp_gray;
    @(posedge clk);
    step_taken = 0;
    if (rst_n) begin
      if (load) begin
        m_bin  = load_is_gray ? gray_inv(int'(load_val)) : int'(load_val);
        m_wrap = 0;
      end else if (en) begin
        hit = model_tc(m_bin, up);
`ifdef GRAY_CNT_SAT_EN
        if (!hit) begin
          m_bin      = (m_bin + (up ? 1 : MAXV)) % (MAXV + 1);
          step_taken = 1;
        end
`else
        m_bin      = (m_bin + (up ? 1 : MAXV)) % (MAXV + 1);
        step_taken = 1;
`endif
        m_wrap = hit;
      end else begin
        m_wrap = 0;
      end
    end
    #1;
    if (check_en) begin
      exp_gray = m_bin ^ (m_bin >> 1);
      checks++;
      if (bin !== W'(m_bin) || gray !== W'(exp_gray) || wrap !== m_wrap ||
          tc !== model_tc(m_bin, up)) begin
        errors++;
        $display("[TB] FAIL model_cmp @%0t: got bin=%b gray=%b wrap=%b tc=%b, expected bin=%b gray=%b wrap=%b tc=%b",
                 $time, bin, gray, wrap, tc, W'(m_bin), W'(exp_gray), m_wrap, model_tc(m_bin, up));
      end
      if (step_taken) begin
        checks++;
        if ($countones(gray ^ last_gray) != 1) begin
          errors++;
          $display("[TB] FAIL one_bit_step @%0t: gray %b -> %b flips %0d bits, expected 1",
                   $time, last_gray, gray, $countones(gray ^ last_gray));
        end
      end
      last_gray = gray;
    end
  end

  task automatic applyStimulus(input bit e, input bit u, input bit l, input bit lg,
                               input logic [W-1:0] v);
    @(negedge clk);
    en           = e;
    up           = u;
    load         = l;
    load_is_gray = lg;
    load_val     = v;
    @(posedge clk);
    #2;
  endtask

  task automatic checkOutput(input string name, input logic [W-1:0] eb,
                             input logic [W-1:0] eg, input bit ew, input bit et);
    checks++;
    if (bin !== eb || gray !== eg || wrap !== ew || tc !== et) begin
      errors++;
      $display("[TB] FAIL %s: got bin=%b gray=%b wrap=%b tc=%b, expected bin=%b gray=%b wrap=%b tc=%b",
               name, bin, gray, wrap, tc, eb, eg, ew, et);
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    en           = 1'b0;
    up           = 1'b1;
    load         = 1'b0;
    load_is_gray = 1'b0;
    load_val     = '0;
    last_gray    = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n    = 1'b1;
    check_en = 1;
    @(posedge clk);
    #2;
    checkOutput("reset", 4'b0000, 4'b0000, 1'b0, 1'b0);

    applyStimulus(0, 1, 1, 0, 4'b1110);
    checkOutput("load_bin", 4'b1110, 4'b1001, 1'b0, 1'b0);
    applyStimulus(0, 1, 1, 1, 4'b1001);
    checkOutput("load_gray", 4'b1110, 4'b1001, 1'b0, 1'b0);

    applyStimulus(1, 1, 0, 0, 4'b0000);
    checkOutput("step_to_ones", 4'b1111, 4'b1000, 1'b0, 1'b1);
    applyStimulus(1, 1, 0, 0, 4'b0000);
`ifdef GRAY_CNT_SAT_EN
    checkOutput("sat_up", 4'b1111, 4'b1000, 1'b1, 1'b1);
    applyStimulus(0, 1, 0, 0, 4'b0000);
    checkOutput("pulse_clear", 4'b1111, 4'b1000, 1'b0, 1'b1);
`else
    checkOutput("wrap_up", 4'b0000, 4'b0000, 1'b1, 1'b0);
    applyStimulus(0, 1, 0, 0, 4'b0000);
    checkOutput("pulse_clear", 4'b0000, 4'b0000, 1'b0, 1'b0);
`endif

    applyStimulus(0, 0, 1, 0, 4'b0000);
    checkOutput("load_zero", 4'b0000, 4'b0000, 1'b0, 1'b1);
    applyStimulus(1, 0, 0, 0, 4'b0000);
`ifdef GRAY_CNT_SAT_EN
    checkOutput("sat_down", 4'b0000, 4'b0000, 1'b1, 1'b1);
`else
    checkOutput("wrap_down", 4'b1111, 4'b1000, 1'b1, 1'b0);
`endif
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1, 0, 0, 0, 4'b0000);
    end
`ifdef GRAY_CNT_SAT_EN
    checkOutput("down_16", 4'b0000, 4'b0000, 1'b1, 1'b1);
`else
    checkOutput("down_16", 4'b1111, 4'b1000, 1'b1, 1'b0);
`endif

    applyStimulus(1, 1, 1, 0, 4'b0101);
    checkOutput("load_over_en", 4'b0101, 4'b0111, 1'b0, 1'b0);
    applyStimulus(1, 1, 0, 0, 4'b0000);
    checkOutput("count_0110", 4'b0110, 4'b0101, 1'b0, 1'b0);

    @(negedge clk);
    en = 1'b0;
    #2 rst_n = 1'b0;
    #1 checkOutput("async_reset", 4'b0000, 4'b0000, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      en           = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) up = ~up;
      load         = ($urandom_range(0, 11) == 0);
      load_is_gray = $urandom_range(0, 1);
      load_val     = W'($urandom_range(0, MAXV));
      if ($urandom_range(0, 249) == 0) begin
        #2 rst_n = 1'b0;
        #1 checkOutput("rand_async_reset", RST_VAL, RST_VAL ^ (RST_VAL >> 1), 1'b0,
                       model_tc(int'(RST_VAL), up));
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    @(negedge clk);
    en   = 1'b0;
    load = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
